matmul_seq_ctrl: RTL
====================

# matmul_seq_ctrl

Sequencer for the UART matrix-multiply datapath. It sits between the UART receiver/transmitter and the A/B operand RAMs plus MAC unit. It takes the matrix size byte and then the A and B elements from the RX byte stream, and writes them into the operand RAMs. It then steps the MAC through every dot product and streams each 16-bit result element out through the TX byte handshake.

## Interface
- MAX_N, 3, largest supported matrix dimension
- AW, 4, operand RAM address width; must satisfy 2^AW ≥ MAX_N*MAX_N
- ACC_W, 20, MAC accumulator width
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
- mem_wdata  out  8  write data to both operand RAMs
- a_we / b_we  out  1 each  write enable, A RAM / B RAM
- a_addr / b_addr  out  AW each  RAM address; RAMs have 1-cycle synchronous read
- mac_en  out  1  MAC accumulates a_rdata*b_rdata this cycle
- mac_clr  out  1  with mac_en: acc = product instead of acc + product
- mac_acc  in  ACC_W  MAC accumulator, valid the cycle after mac_en
- busy  out  1  high in every state except LOAD_N
- size_err  out  1  one-cycle pulse on an illegal size byte
- rx_drop  out  1  one-cycle pulse when a byte arrives in COMPUTE/SEND and is discarded

## Operation
- Addressing is row-major with fixed stride MAX_N: element [r][c] is at r*MAX_N + c.
- States are LOAD_N, LOAD_A, LOAD_B, ISSUE, DRAIN, CAPTURE, SEND_HI, SEND_LO.
- LOAD_N:
  - On rx_valid with 1 ≤ rx_data ≤ MAX_N, latch N, clear r/c, go to LOAD_A.
  - Otherwise pulse size_err and stay.
- LOAD_A: each rx_valid writes the byte to A[r][c] (a_we=1 for that cycle, mem_wdata=rx_data), then advances c, then r. After element N*N, go to LOAD_B.
- LOAD_B: same as LOAD_A into B. After the last element, set i=j=k=0 and go to ISSUE.
- ISSUE:
  - Each cycle drives a_addr=A[i][k] and b_addr=B[k][j], then increments k.
  - After k=N-1, go to DRAIN.
  - mac_en is the issue strobe registered by one cycle; mac_clr is asserted with the mac_en for k=0.
- DRAIN: the last mac_en is issued; go to CAPTURE.
- CAPTURE: latch mac_acc into a 16-bit result register (see Configuration); go to SEND_HI.
- SEND_HI / SEND_LO:
  - tx_valid=1 with result[15:8], then result[7:0].
  - Advance only on tx_valid & tx_ready.
- After SEND_LO: advance j, then i.
  - If elements remain: set k=0 and go to ISSUE.
  - Otherwise go to LOAD_N.
- rx_valid in ISSUE through SEND_LO: the byte is discarded and rx_drop pulses.
- The multiply is 8×8 unsigned. Accumulation is in ACC_W bits; N=MAX_N=3 at 255 gives at most 195075, which fits 18 bits.

## Timing
- Reset values:
  - State LOAD_N; N, r, c, i, j, k and result all 0.
  - All outputs 0 except busy=0.
- RX write: a_we/b_we assert in the cycle after rx_valid (registered).
- Per result element:
  - N ISSUE + 1 DRAIN + 1 CAPTURE cycles.
  - Then ≥2 cycles of TX handshake.
- tx_data and tx_valid are registered and stable while tx_ready=0. Backpressure of any length stalls the sequencer with no loss.
- tx_valid deasserts in the cycle after the final accepted byte.
- LOAD_N and ISSUE are re-entered with all counters zeroed; no stale k carries over.
- Reset asserted mid-operation returns everything to reset values immediately. Already-written RAM contents are don't-care; a new size byte is required.

## Configuration
- MATMUL_SAT_EN defined: result = (mac_acc > 16'hFFFF) ? 16'hFFFF : mac_acc[15:0].
- MATMUL_SAT_EN undefined: result = mac_acc[15:0] (silent truncation).

## Test plan
- Basic 2×2: size byte 02, A=01 02 03 04, B=05 06 07 08 -> TX bytes 00 13 00 16 00 2B 00 32, then busy=0.
- Saturation: size byte 03, all 18 elements FF -> nine results.
  - With MATMUL_SAT_EN: each result sent as FF FF.
  - Without: each result sent as FA 03.
- Illegal size:
  - Size byte 00 -> size_err pulse, state stays LOAD_N.
  - Size byte 04 (MAX_N=3) -> same.
  - A following 01 is then accepted as N=1.
- Backpressure: hold tx_ready=0 for 50 cycles during SEND_HI -> tx_data/tx_valid stable; sequence resumes with no missing or duplicated bytes.
- Drop: inject rx_valid during ISSUE -> rx_drop pulses, RAMs are not written, results are unchanged.
- Reset mid-ISSUE: assert rst -> all outputs 0 within the reset cycle; a fresh 1×1 run (01, 03, 05) -> TX bytes 00 0F.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the UART matrix-multiply datapath: loads N, A and B from RX bytes,
// steps the MAC through every dot product and streams 16-bit results over TX.
// Optional feature: define MATMUL_SAT_EN to saturate results at 16'hFFFF instead of truncating.
module matmul_seq_ctrl #(
    parameter int MAX_N = 3,
    parameter int AW    = 4,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       mem_wdata,
    output logic             a_we,
    output logic             b_we,
    output logic [AW-1:0]    a_addr,
    output logic [AW-1:0]    b_addr,
    output logic             mac_en,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             busy,
    output logic             size_err,
    output logic             rx_drop
);

    localparam int CW = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {
        LOAD_N,
        LOAD_A,
        LOAD_B,
        ISSUE,
        DRAIN,
        CAPTURE,
        SEND_HI,
        SEND_LO
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] n_q;
    logic [CW-1:0] r_q;
    logic [CW-1:0] c_q;
    logic [CW-1:0] i_q;
    logic [CW-1:0] j_q;
    logic [CW-1:0] k_q;
    logic [15:0]   result_q;
    logic [AW-1:0] wr_addr_q;
    logic          b_last_q;

    logic [CW-1:0] n_last;
    logic          size_ok;
    logic          rc_last;
    logic          k_last;
    logic          ij_last;
    logic          tx_fire;
    logic          load_wr;
    logic          drop_now;
    logic [15:0]   result_next;

    function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] row, input logic [CW-1:0] col);
        return AW'(row) * AW'(MAX_N) + AW'(col);
    endfunction

    assign n_last   = n_q - CW'(1);
    assign size_ok  = (rx_data != 8'd0) && (rx_data <= 8'(MAX_N));
    assign rc_last  = (r_q == n_last) && (c_q == n_last);
    assign k_last   = (k_q == n_last);
    assign ij_last  = (i_q == n_last) && (j_q == n_last);
    assign tx_fire  = tx_valid && tx_ready;
    assign busy     = (state != LOAD_N);

    // The final B write is still in flight for one cycle, so LOAD_B lingers before ISSUE.
    assign load_wr  = rx_valid && ((state == LOAD_A) || (state == LOAD_B && !b_last_q));
    assign drop_now = rx_valid && ((state inside {ISSUE, DRAIN, CAPTURE, SEND_HI, SEND_LO}) ||
                                   (state == LOAD_B && b_last_q));

    // Read addresses are combinational in ISSUE so RAM data lines up with the registered mac_en.
    assign a_addr = (state == ISSUE) ? addr_of(i_q, k_q) : wr_addr_q;
    assign b_addr = (state == ISSUE) ? addr_of(k_q, j_q) : wr_addr_q;

`ifdef MATMUL_SAT_EN
    assign result_next = (mac_acc > ACC_W'(16'hFFFF)) ? 16'hFFFF : mac_acc[15:0];
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^mac_acc[ACC_W-1:16];
    assign result_next   = mac_acc[15:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_N;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_N:  if (rx_valid && size_ok) state_next = LOAD_A;
            LOAD_A:  if (rx_valid && rc_last) state_next = LOAD_B;
            LOAD_B:  if (b_last_q) state_next = ISSUE;
            ISSUE:   if (k_last) state_next = DRAIN;
            DRAIN:   state_next = CAPTURE;
            CAPTURE: state_next = SEND_HI;
            SEND_HI: if (tx_fire) state_next = SEND_LO;
            SEND_LO: if (tx_fire) state_next = ij_last ? LOAD_N : ISSUE;
            default: state_next = LOAD_N;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            result_q  <= '0;
            wr_addr_q <= '0;
            b_last_q  <= 1'b0;
            mem_wdata <= '0;
            a_we      <= 1'b0;
            b_we      <= 1'b0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            size_err  <= 1'b0;
            rx_drop   <= 1'b0;
        end else begin
            a_we     <= 1'b0;
            b_we     <= 1'b0;
            size_err <= 1'b0;
            b_last_q <= 1'b0;
            rx_drop  <= drop_now;
            mac_en   <= (state == ISSUE);
            mac_clr  <= (state == ISSUE) && (k_q == '0);

            if (state == LOAD_N && rx_valid) begin
                if (size_ok) begin
                    n_q <= rx_data[CW-1:0];
                    r_q <= '0;
                    c_q <= '0;
                end else begin
                    size_err <= 1'b1;
                end
            end

            // Operand load: row-major walk of r/c, write strobe issued one cycle later.
            if (load_wr) begin
                mem_wdata <= rx_data;
                wr_addr_q <= addr_of(r_q, c_q);
                a_we      <= (state == LOAD_A);
                b_we      <= (state == LOAD_B);
                if (c_q == n_last) begin
                    c_q <= '0;
                    r_q <= rc_last ? '0 : r_q + CW'(1);
                end else begin
                    c_q <= c_q + CW'(1);
                end
                if (state == LOAD_B && rc_last) begin
                    b_last_q <= 1'b1;
                end
            end

            if (state == LOAD_B && b_last_q) begin
                i_q <= '0;
                j_q <= '0;
                k_q <= '0;
            end

            if (state == ISSUE) begin
                k_q <= k_last ? '0 : k_q + CW'(1);
            end

            if (state == CAPTURE) begin
                result_q <= result_next;
                tx_data  <= result_next[15:8];
                tx_valid <= 1'b1;
            end

            if (state == SEND_HI && tx_fire) begin
                tx_data <= result_q[7:0];
            end

            // After the low byte leaves, step j then i; all counters are clean for the next pass.
            if (state == SEND_LO && tx_fire) begin
                tx_valid <= 1'b0;
                k_q      <= '0;
                if (j_q == n_last) begin
                    j_q <= '0;
                    i_q <= (i_q == n_last) ? '0 : i_q + CW'(1);
                end else begin
                    j_q <= j_q + CW'(1);
                end
                if (ij_last) begin
                    r_q <= '0;
                    c_q <= '0;
                end
            end
        end
    end

endmodule
